// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array feeder.
//   feeder_state_t : controller states (IDLE, RUN, DONE)
//   run_len()      : number of feed steps for an M x K by K x N product with a
//                    given PE MAC latency. Used by RTL and by the bench.
// -----------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } feeder_state_t;

    // The last operand pair reaches PE(M-1,N-1) at step K+M+N-3; the extra
    // PE_LATENCY steps let that final MAC retire before done is raised.
    function automatic int run_len(input int m, input int k, input int n, input int lat);
        return k + m + n - 2 + lat;
    endfunction

endpackage

// File: rtl/feed_lane_mux.sv
// -----------------------------------------------------------------------------
// feed_lane_mux
// Picks the element a single edge lane presents at step t. A lane with index L
// is skewed by L steps, so it shows i_vec[t-L] while 0 <= t-L < K, else 0.
//   i_lane : lane index (row i for the left edge, column j for the top edge)
//   i_t    : step index
//   i_vec  : snapshot row (left edge) or column (top edge), K elements
//   o_elem : selected element or 0
// -----------------------------------------------------------------------------
module feed_lane_mux
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int K          = 4,
    parameter int TW         = 4
) (
    input  logic [TW-1:0]                 i_lane,
    input  logic [TW-1:0]                 i_t,
    input  logic [0:K-1][DATA_WIDTH-1:0]  i_vec,
    output logic [DATA_WIDTH-1:0]         o_elem
);

    logic [TW-1:0] w_off;

    always_comb begin
        w_off  = i_t - i_lane;
        o_elem = '0;
        // Guarding on t >= lane keeps the subtraction from wrapping into a
        // bogus in-window offset.
        if (i_t >= i_lane) begin
            for (int idx = 0; idx < K; idx++) begin
                if (w_off == TW'(idx)) begin
                    o_elem = i_vec[idx];
                end
            end
        end
    end

endmodule

// File: rtl/matrix_feeder.sv
// -----------------------------------------------------------------------------
// matrix_feeder
// Snapshots a weight matrix W (M x K) and a data matrix B (K x N) on start and
// streams them, skewed, into the left and top edges of an M x N systolic
// array. A run lasts R = K+M+N-2+PE_LATENCY steps, then done pulses once.
//
// Ports
//   clk, reset_n  : clock, asynchronous active-low reset
//   start         : one-cycle run request (honoured only in IDLE)
//   stall         : (MATRIX_FEEDER_STALL_EN only) pauses the run
//   data_rom_w    : weight matrix, [row][col]
//   data_rom_b    : data matrix, [row][col]
//   a_left        : left-edge lanes, lane i carries W[i][t-i]
//   b_top         : top-edge lanes, lane j carries B[t-j][j]
//   feed_valid    : array advances one step
//   clear_acc     : zero the PE accumulators (same cycle as accepted start)
//   busy, done    : run in progress / result complete pulse
//
// Build option
//   MATRIX_FEEDER_STALL_EN : adds the stall input. Without it every run is
//                            exactly R cycles.
//
// States
//   ST_IDLE | waiting for start
//   ST_RUN  | presenting steps 0..R-1 (or stall bubbles)
//   ST_DONE | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module matrix_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W_W  = 4,
    parameter int ARRAY_W_L  = 4,
    parameter int ARRAY_A_W  = 4,
    parameter int ARRAY_A_L  = 4,
    parameter int PE_LATENCY = 1
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          start,
`ifdef MATRIX_FEEDER_STALL_EN
    input  logic                                          stall,
`endif
    input  logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0] data_rom_w,
    input  logic [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0] data_rom_b,
    output logic [0:ARRAY_W_W-1][DATA_WIDTH-1:0]          a_left,
    output logic [0:ARRAY_A_L-1][DATA_WIDTH-1:0]          b_top,
    output logic                                          feed_valid,
    output logic                                          clear_acc,
    output logic                                          busy,
    output logic                                          done
);

    localparam int M  = ARRAY_W_W;
    localparam int KW = ARRAY_W_L;
    localparam int KA = ARRAY_A_W;
    localparam int N  = ARRAY_A_L;
    localparam int R  = run_len(M, KW, N, PE_LATENCY);
    localparam int TW = $clog2(R + 1);
    localparam logic [TW-1:0] T_LAST = TW'(R - 1);

    feeder_state_t r_state;
    feeder_state_t w_state_nxt;
    logic [TW-1:0] r_t;
    logic [TW-1:0] w_t_nxt;
    logic          w_fv_nxt;
    logic          w_stall;
    logic          w_start_run;

    logic [0:M-1][0:KW-1][DATA_WIDTH-1:0] r_w;
    logic [0:KA-1][0:N-1][DATA_WIDTH-1:0] r_b;
    logic [0:M-1][0:KW-1][DATA_WIDTH-1:0] w_w_src;
    logic [0:KA-1][0:N-1][DATA_WIDTH-1:0] w_b_src;
    logic [0:N-1][0:KA-1][DATA_WIDTH-1:0] w_b_col;
    logic [0:M-1][DATA_WIDTH-1:0]         w_a_lane;
    logic [0:N-1][DATA_WIDTH-1:0]         w_b_lane;

    logic                         r_fv;
    logic                         r_busy;
    logic                         r_done;
    logic [0:M-1][DATA_WIDTH-1:0] r_a_left;
    logic [0:N-1][DATA_WIDTH-1:0] r_b_top;

`ifdef MATRIX_FEEDER_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_start_run = (r_state == ST_IDLE) && start;

    // Bubble handling: r_t is the step on the lanes when r_fv is high, and the
    // step still pending when r_fv is low (a stall bubble). A step is only
    // retired after it has been shown with r_fv high.
    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_fv_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_t_nxt     = '0;
                    w_fv_nxt    = 1'b1;
                end
            end
            ST_RUN: begin
                if (r_fv) begin
                    if (r_t == T_LAST) begin
                        w_state_nxt = ST_DONE;
                        w_t_nxt     = '0;
                    end else begin
                        w_t_nxt  = r_t + 1'b1;
                        w_fv_nxt = !w_stall;
                    end
                end else begin
                    w_fv_nxt = !w_stall;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_t_nxt     = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_t_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_t     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
        end
    end

    // The t=0 step must be on the lanes right after the start edge, so on that
    // edge the lane muxes read the input ports instead of the snapshot.
    assign w_w_src = w_start_run ? data_rom_w : r_w;
    assign w_b_src = w_start_run ? data_rom_b : r_b;

    for (genvar j = 0; j < N; j++) begin : g_col
        for (genvar k = 0; k < KA; k++) begin : g_elem
            assign w_b_col[j][k] = w_b_src[k][j];
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_a_lane
        feed_lane_mux #(
            .DATA_WIDTH (DATA_WIDTH),
            .K          (KW),
            .TW         (TW)
        ) u_mux (
            .i_lane (TW'(i)),
            .i_t    (w_t_nxt),
            .i_vec  (w_w_src[i]),
            .o_elem (w_a_lane[i])
        );
    end

    for (genvar j = 0; j < N; j++) begin : g_b_lane
        feed_lane_mux #(
            .DATA_WIDTH (DATA_WIDTH),
            .K          (KA),
            .TW         (TW)
        ) u_mux (
            .i_lane (TW'(j)),
            .i_t    (w_t_nxt),
            .i_vec  (w_b_col[j]),
            .o_elem (w_b_lane[j])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_w <= '0;
            r_b <= '0;
        end else if (w_start_run) begin
            r_w <= data_rom_w;
            r_b <= data_rom_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fv     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_a_left <= '0;
            r_b_top  <= '0;
        end else begin
            r_fv     <= w_fv_nxt;
            r_busy   <= (w_state_nxt == ST_RUN);
            r_done   <= (w_state_nxt == ST_DONE);
            r_a_left <= w_fv_nxt ? w_a_lane : '0;
            r_b_top  <= w_fv_nxt ? w_b_lane : '0;
        end
    end

    assign a_left     = r_a_left;
    assign b_top      = r_b_top;
    assign feed_valid = r_fv;
    assign busy       = r_busy;
    assign done       = r_done;
    // Combinational so the accumulators clear on the start edge, one edge
    // before the first operand pair is consumed.
    assign clear_acc  = reset_n && w_start_run;

endmodule

// File: doc/matrix_feeder.md
MATRIX_FEEDER -- requirements
Module: matrix_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 8: element width in bits.
REQ-002 Parameter ARRAY_W_W, default 4: weight rows (M), equal to the number of left-edge lanes.
REQ-003 Parameter ARRAY_W_L, default 4: weight columns (K); SHALL equal ARRAY_A_W.
REQ-004 Parameter ARRAY_A_W, default 4: data rows (K).
REQ-005 Parameter ARRAY_A_L, default 4: data columns (N), equal to the number of top-edge lanes.
REQ-006 Parameter PE_LATENCY, default 1: pipeline latency of one PE MAC, in cycles.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  one-cycle request to begin a run.
REQ-010 data_rom_w  input  [0:M-1][0:K-1][DATA_WIDTH]  weight matrix.
REQ-011 data_rom_b  input  [0:K-1][0:N-1][DATA_WIDTH]  data matrix.
REQ-012 a_left  output  [0:M-1][DATA_WIDTH]  skewed row stream into the array's left edge.
REQ-013 b_top  output  [0:N-1][DATA_WIDTH]  skewed column stream into the array's top edge.
REQ-014 feed_valid  output  1  array advances one step when high.
REQ-015 clear_acc  output  1  one-cycle pulse that zeroes the PE accumulators.
REQ-016 busy  output  1  high while a run is in progress.
REQ-017 done  output  1  one-cycle pulse when the result matrix is complete.

Function
REQ-018 States SHALL be IDLE, RUN and DONE; reset enters IDLE.
REQ-019 In IDLE, start=1 SHALL snapshot both matrices into internal registers, pulse clear_acc in the same cycle, zero the step counter t, and move to RUN.
REQ-020 Run length SHALL be R = K+M+N-2+PE_LATENCY steps; t counts 0..R-1, one step per cycle.
REQ-021 RUN outputs SHALL be registered, with step t visible in the t-th cycle after the start edge (t=0 on the first cycle).
REQ-022 feed_valid and busy SHALL be high for every RUN cycle.
REQ-023 a_left[i] SHALL equal W[i][t-i] when 0<=t-i<K, else 0.
REQ-024 b_top[j] SHALL equal B[t-j][j] when 0<=t-j<K, else 0.
REQ-025 Step index arithmetic SHALL use $clog2(R+1)-bit unsigned math with no negative wrap; out-of-window lanes SHALL be 0.
REQ-026 After step R-1, the block SHALL enter DONE for exactly one cycle with done=1, busy=0 and feed_valid=0, then return to IDLE.
REQ-027 start while in RUN or DONE SHALL be ignored and not queued.
REQ-028 Input matrix changes during RUN SHALL NOT affect the run in progress.
REQ-029 start in the cycle IDLE is re-entered SHALL begin a new run.

Reset
REQ-030 reset_n=0 SHALL immediately force IDLE and t=0, and drive every output to 0 (a_left, b_top, feed_valid, clear_acc, busy, done).
REQ-031 Reset during RUN SHALL abort the run with no done pulse.

Configuration
REQ-032 With MATRIX_FEEDER_STALL_EN defined, an input port stall (1 bit) SHALL exist. While stall=1 in RUN, t holds, feed_valid=0 and a_left/b_top are 0; at stall=0 the run resumes at the held t. stall has no effect in IDLE or DONE.
REQ-033 Without MATRIX_FEEDER_STALL_EN, the stall port SHALL be absent and the run is always exactly R cycles.

Structure
REQ-034 Package systolic_pkg SHALL hold the state enum and a constant function run_len(M,K,N,lat) used by RTL and bench.
REQ-035 One sub-module, feed_lane_mux, SHALL select a lane element or 0 from lane index, t and the snapshot row/column; it is instantiated M+N times.

Verification
REQ-036 M=2, K=5, N=2, W rows {00..04} and {0a..0e}, B rows {00,01}..{08,09}, start pulse: R=8, feed_valid is high for 8 cycles, and one done pulse follows.
REQ-037 Same run: a_left[1] is 0 at t=0, 0x0a at t=1 and 0x0e at t=5; b_top[1] is 0 at t=0, 0x01 at t=1 and 0x09 at t=5; all lanes are 0 at t=7.
REQ-038 Feed into a reference systolic array model: the result is {003c,0046},{0104,0140} at the done pulse.
REQ-039 start re-pulsed at t=3: no restart, and done still occurs at the original cycle.
REQ-040 reset_n low at t=4: all outputs are 0 asynchronously, and no done pulse occurs; a new start then runs a full R cycles.
REQ-041 (STALL_EN) stall held for 3 cycles at t=2: a_left/b_top stay 0 and feed_valid=0 during the stall; done arrives 3 cycles late and the result matrix is unchanged.
